svm_recall_seq: RTL and testbench

Sequential, parametrised linear-SVM recall engine. It holds a DIM-element sign-magnitude weight vector, accepts a DIM-element sign-magnitude feature vector over a valid/ready handshake, and accumulates w·x (+ bias) with one multiply-accumulate per cycle. It returns the signed score and the class decision over a second valid/ready handshake. It replaces the two-element combinational recall path and sits between the feature-capture front end and the classification consumer.

---
 rtl/svm_pkg.sv | 27 ++
 rtl/svm_recall_seq_if.sv | 46 ++++
 rtl/svm_sm_mult.sv | 26 ++
 rtl/svm_recall_seq.sv | 128 ++++++++++++
 tb/tb_svm_recall_seq.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/svm_pkg.sv
// Shared types and helpers for the sequential linear-SVM recall engine.
// Optional bias support is enabled with SVM_RECALL_BIAS_EN.
package svm_pkg;

  localparam int MAG_W_DEF = 7;
  localparam int SM_MAX    = 32;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  localparam logic [SM_MAX:0] SM_ONE = 1;

  // Sign-magnitude (sign at bit mw) to two's complement; -0 maps to 0.
  function automatic logic signed [SM_MAX:0] sm_to_twos(
    input logic [SM_MAX-1:0] v,
    input int                mw
  );
    logic [SM_MAX:0] mag;
    mag = {1'b0, v} & ((SM_ONE << mw) - SM_ONE);
    if (v[mw] && (mag != '0)) return -$signed(mag);
    return $signed(mag);
  endfunction

endpackage

// File: rtl/svm_recall_seq_if.sv
// Weight-write, feature-input and result handshake bundle.
// Bias write fields exist only with SVM_RECALL_BIAS_EN.
interface svm_recall_seq_if
  import svm_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int MAG_W = MAG_W_DEF,
  parameter int ACC_W = 2*MAG_W+$clog2(DIM)+1
);

  logic                     wr_en;
  logic [$clog2(DIM)-1:0]   wr_addr;
  logic [MAG_W:0]           wr_data;
`ifdef SVM_RECALL_BIAS_EN
  logic                     bias_wr_en;
  logic [ACC_W-1:0]         bias_data;
`endif
  logic                     in_valid;
  logic                     in_ready;
  logic [DIM*(MAG_W+1)-1:0] in_vec;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_W-1:0]         out_score;
  logic                     out_result;

  modport slave (
`ifdef SVM_RECALL_BIAS_EN
    input  bias_wr_en, bias_data,
`endif
    input  wr_en, wr_addr, wr_data,
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid,
    output out_score, out_result
  );

  modport master (
`ifdef SVM_RECALL_BIAS_EN
    output bias_wr_en, bias_data,
`endif
    output wr_en, wr_addr, wr_data,
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid,
    input  out_score, out_result
  );

endinterface

// File: rtl/svm_sm_mult.sv
// Combinational sign-magnitude multiplier with an exact
// two's-complement product.
module svm_sm_mult
  import svm_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic [MAG_W:0]          a_i,
  input  logic [MAG_W:0]          b_i,
  output logic signed [2*MAG_W:0] p_o
);

  localparam int P = 2*MAG_W+1;

  logic signed [SM_MAX:0] ta;
  logic signed [SM_MAX:0] tb;
  logic signed [P-1:0]    pa;
  logic signed [P-1:0]    pb;

  assign ta  = sm_to_twos(SM_MAX'(a_i), MAG_W);
  assign tb  = sm_to_twos(SM_MAX'(b_i), MAG_W);
  assign pa  = P'(ta);
  assign pb  = P'(tb);
  assign p_o = pa * pb;

endmodule

// File: rtl/svm_recall_seq.sv
// Sequential linear-SVM recall: one MAC per cycle over DIM elements.
// Define SVM_RECALL_BIAS_EN to add a writable accumulator bias.
module svm_recall_seq
  import svm_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int MAG_W = MAG_W_DEF,
  parameter int ACC_W = 2*MAG_W+$clog2(DIM)+1
) (
  input  logic             clk,
  input  logic             rst_n,
  svm_recall_seq_if.slave  bus
);

  localparam int EW      = MAG_W+1;
  localparam int AW      = $clog2(DIM);
  localparam int PW      = 2*MAG_W+1;
  localparam int ACC_MIN = 2*MAG_W+$clog2(DIM)+1;

  if (ACC_W < ACC_MIN) begin : g_acc_chk
    $error("svm_recall_seq: ACC_W too small");
  end

  state_t                  state_q, state_d;
  logic [EW-1:0]           w_q [DIM];
  logic [DIM*EW-1:0]       x_q, x_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] bias_cur;
  logic                    accept;
  logic                    w_we;
  logic                    last;
  logic [EW-1:0]           w_sel;
  logic [EW-1:0]           x_sel;
  logic signed [PW-1:0]    prod;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (idx_q == AW'(DIM-1));
  assign w_we   = (state_q == IDLE) && bus.wr_en &&
                  (32'(bus.wr_addr) < 32'(DIM));

`ifdef SVM_RECALL_BIAS_EN
  logic signed [ACC_W-1:0] bias_q;
  logic                    b_we;

  assign b_we = (state_q == IDLE) && bus.bias_wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) bias_q <= '0;
    else if (b_we) bias_q <= bus.bias_data;
  end

  // A bias written on the accept edge seeds this run.
  assign bias_cur = b_we ? bus.bias_data : bias_q;
`else
  assign bias_cur = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++) w_q[i] <= '0;
    end else if (w_we) begin
      w_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign w_sel = w_q[idx_q];
  assign x_sel = x_q[idx_q*EW +: EW];

  svm_sm_mult #(.MAG_W(MAG_W)) u_mult (
    .a_i (w_sel),
    .b_i (x_sel),
    .p_o (prod)
  );

  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    x_d   = x_q;
    unique case (1'b1)
      accept: begin
        acc_d = bias_cur;
        idx_d = '0;
        x_d   = bus.in_vec;
      end
      (state_q == MAC): begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = last ? '0 : idx_q + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      idx_q <= '0;
      x_q   <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      x_q   <= x_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MAC;
      MAC:     if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = rst_n && (state_q == IDLE);
    bus.out_valid  = rst_n && (state_q == DONE);
    bus.out_score  = acc_q;
    bus.out_result = ~acc_q[ACC_W-1];
  end

endmodule

// File: tb/tb_svm_recall_seq.sv
// Directed bench for svm_recall_seq (DIM=4, MAG_W=7, ACC_W=17).
module tb_svm_recall_seq;

  localparam int DIM   = 4;
  localparam int MAG_W = 7;
  localparam int ACC_W = 17;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  svm_recall_seq_if #(
    .DIM(DIM), .MAG_W(MAG_W), .ACC_W(ACC_W)
  ) bus ();

  svm_recall_seq #(
    .DIM(DIM), .MAG_W(MAG_W), .ACC_W(ACC_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sm(input int v);
    if (v < 0) return {1'b1, 7'(-v)};
    return {1'b0, 7'(v)};
  endfunction

  function automatic logic [31:0] vec4(
    input int a, input int b, input int c, input int d
  );
    return {sm(d), sm(c), sm(b), sm(a)};
  endfunction

  task automatic write_w(
    input logic [7:0] w0, input logic [7:0] w1,
    input logic [7:0] w2, input logic [7:0] w3
  );
    logic [7:0] ws [4];
    ws = '{w0, w1, w2, w3};
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 2'(i);
      bus.wr_data = ws[i];
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
  endtask

  task automatic do_run(
    input  logic [31:0] v,
    output int          lat,
    output logic [16:0] sc,
    output logic        res
  );
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sc  = bus.out_score;
    res = bus.out_result;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL rst_in_ready got %b want 0", bus.in_ready);
    else passed++;
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.out_score !== 17'd0)
      $display("FAIL rst_score got %0h want 0", bus.out_score);
    else passed++;
    checks++;
    if (bus.out_result !== 1'b1)
      $display("FAIL rst_result got %b want 1", bus.out_result);
    else passed++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rst_release_rdy got %b want 1", bus.in_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; logic [16:0] sc; logic res;
    write_w(sm(3), sm(-2), sm(5), sm(0));
    do_run(vec4(10, 10, -1, 7), lat, sc, res);
    checks++;
    if (lat !== 4) $display("FAIL basic_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (sc !== 17'd5) $display("FAIL basic_score got %0d want 5", sc);
    else passed++;
    checks++;
    if (res !== 1'b1) $display("FAIL basic_result got %b want 1", res);
    else passed++;
    checks++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL basic_rdy_done got %b want 0", bus.in_ready);
    else passed++;
    release_out();
    checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL basic_vld_clr got %b want 0", bus.out_valid);
    else passed++;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL basic_rdy_back got %b want 1", bus.in_ready);
    else passed++;
  endtask

  task automatic test_neg_zero();
    int lat; logic [16:0] sc; logic res;
    write_w(sm(1), sm(-1), 8'h80, sm(0));
    do_run(vec4(4, 4, 9, 0), lat, sc, res);
    checks++;
    if (lat !== 4) $display("FAIL nz_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (sc !== 17'd0) $display("FAIL nz_score got %0d want 0", sc);
    else passed++;
    checks++;
    if (res !== 1'b1) $display("FAIL nz_result got %b want 1", res);
    else passed++;
    release_out();
  endtask

  task automatic test_extreme();
    int lat; logic [16:0] sc; logic res;
    logic [16:0] exp_sc;
    exp_sc = 17'd66556;
    write_w(sm(-127), sm(-127), sm(-127), sm(-127));
    do_run(vec4(127, 127, 127, 127), lat, sc, res);
    checks++;
    if (lat !== 4) $display("FAIL ext_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (sc !== exp_sc)
      $display("FAIL ext_score got %0h want %0h", sc, exp_sc);
    else passed++;
    checks++;
    if (res !== 1'b0) $display("FAIL ext_result got %b want 0", res);
    else passed++;
    release_out();
  endtask

  task automatic test_backpressure();
    int lat; logic [16:0] sc; logic res;
    write_w(sm(3), sm(-2), sm(5), sm(0));
    do_run(vec4(10, 10, -1, 7), lat, sc, res);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'b1;
      bus.in_vec   = vec4(1, 1, 1, 1);
      bus.wr_en    = 1'b1;
      bus.wr_addr  = 2'd0;
      bus.wr_data  = sm(100);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1)
        $display("FAIL bp_valid c%0d got %b want 1", c, bus.out_valid);
      else passed++;
      checks++;
      if (bus.out_score !== 17'd5)
        $display("FAIL bp_score c%0d got %0d want 5", c, bus.out_score);
      else passed++;
      checks++;
      if (bus.out_result !== 1'b1)
        $display("FAIL bp_result c%0d got %b want 1", c, bus.out_result);
      else passed++;
      checks++;
      if (bus.in_ready !== 1'b0)
        $display("FAIL bp_rdy c%0d got %b want 0", c, bus.in_ready);
      else passed++;
    end
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b0;
    release_out();
    do_run(vec4(10, 10, -1, 7), lat, sc, res);
    checks++;
    if (lat !== 4) $display("FAIL bp2_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (sc !== 17'd5) $display("FAIL bp2_score got %0d want 5", sc);
    else passed++;
    checks++;
    if (res !== 1'b1) $display("FAIL bp2_result got %b want 1", res);
    else passed++;
    release_out();
  endtask

  task automatic test_write_on_accept();
    int lat; logic [16:0] sc; logic res;
    write_w(sm(3), sm(-2), sm(5), sm(0));
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'd3;
    bus.wr_data = sm(2);
    do_run(vec4(10, 10, -1, 7), lat, sc, res);
    bus.wr_en = 1'b0;
    checks++;
    if (lat !== 4) $display("FAIL wacc_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (sc !== 17'd19) $display("FAIL wacc_score got %0d want 19", sc);
    else passed++;
    release_out();
  endtask

  task automatic test_reset_mid();
    int lat; logic [16:0] sc; logic res;
    logic seen;
    write_w(sm(3), sm(-2), sm(5), sm(0));
    bus.in_valid = 1'b1;
    bus.in_vec   = vec4(10, 10, -1, 7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL mid_rdy got %b want 1", bus.in_ready);
    else passed++;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL mid_novalid got %b want 0", seen);
    else passed++;
    do_run(vec4(10, 10, -1, 7), lat, sc, res);
    checks++;
    if (lat !== 4) $display("FAIL mid_lat got %0d want 4", lat);
    else passed++;
    checks++;
    if (sc !== 17'd0) $display("FAIL mid_score got %0d want 0", sc);
    else passed++;
    checks++;
    if (res !== 1'b1) $display("FAIL mid_result got %b want 1", res);
    else passed++;
    release_out();
  endtask

  task automatic test_bias();
    int lat; logic [16:0] sc; logic res;
    logic [16:0] exp_sc;
    logic        exp_res;
    write_w(sm(3), sm(-2), sm(5), sm(0));
`ifdef SVM_RECALL_BIAS_EN
    bus.bias_wr_en = 1'b1;
    bus.bias_data  = 17'h1FFFA;
    @(negedge clk);
    bus.bias_wr_en = 1'b0;
    exp_sc  = 17'h1FFFF;
    exp_res = 1'b0;
`else
    exp_sc  = 17'd5;
    exp_res = 1'b1;
`endif
    do_run(vec4(10, 10, -1, 7), lat, sc, res);
    checks++;
    if (sc !== exp_sc)
      $display("FAIL bias_score got %0h want %0h", sc, exp_sc);
    else passed++;
    checks++;
    if (res !== exp_res)
      $display("FAIL bias_result got %b want %b", res, exp_res);
    else passed++;
    release_out();
  endtask

  initial begin
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
`ifdef SVM_RECALL_BIAS_EN
    bus.bias_wr_en = 1'b0;
    bus.bias_data  = '0;
`endif
    test_reset();
    test_basic();
    test_neg_zero();
    test_extreme();
    test_backpressure();
    test_write_on_accept();
    test_reset_mid();
    test_bias();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
